reorder_buffer: RTL and testbench

- In-order retirement buffer of the out-of-order core.
- Allocates entries for renamed instructions and returns their ROB indices to renaming/RAT.
- Collects out-of-order completion results from the commit stage (ALU/MEM/branch) and retires the oldest completed entries in program order to RAT/ARF/CP0/HILO.
- Drives rob_full to the hazard unit and the mispredict redirect (branch_taken, pcbranch) to pcselect.

---
 rtl/rob_pkg.sv | 33 +++
 rtl/reorder_buffer_if.sv | 43 ++++
 rtl/rob_entry_array.sv | 43 ++++
 rtl/reorder_buffer.sv | 104 ++++++++++
 tb/tb_reorder_buffer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared sizing, pointer and entry types for the reorder buffer
package rob_pkg;
   localparam int ROB_DEPTH     = 16;
   localparam int ROB_AW        = $clog2(ROB_DEPTH);
   localparam int MACHINE_WIDTH = 2;
   localparam int ALU_NUM       = 2;
   localparam int MEM_NUM       = 1;
   localparam int RETIRE_WIDTH  = 2;
   localparam int PREG_W        = 6;
   localparam int CMT_NUM       = 2 * ALU_NUM + MEM_NUM;

   typedef logic [ROB_AW-1:0] rob_addr_t;
   typedef logic [ROB_AW:0]   rob_ptr_t;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              mispredict;
      logic [4:0]        dst;
      logic [PREG_W-1:0] preg;
      logic [31:0]       data;
      logic [31:0]       target;
   } rob_entry_t;

   // br selects whether data lands in the result field or the redirect target
   typedef struct packed {
      logic        valid;
      logic        br;
      logic        taken;
      rob_addr_t   rob;
      logic [31:0] data;
   } cmt_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: allocation, completion, retirement and redirect bundle of the ROB
interface reorder_buffer_if;
   import rob_pkg::*;
   logic                              flush;
   logic [MACHINE_WIDTH-1:0]          alloc_valid;
   logic [MACHINE_WIDTH*5-1:0]        alloc_dst;
   logic [MACHINE_WIDTH*PREG_W-1:0]   alloc_preg;
   logic [MACHINE_WIDTH*ROB_AW-1:0]   rob_addr_new;
   logic                              rob_full;
   logic [ALU_NUM-1:0]                alu_commit_valid;
   logic [ALU_NUM*ROB_AW-1:0]         alu_commit_rob;
   logic [ALU_NUM*32-1:0]             alu_commit_data;
   logic [MEM_NUM-1:0]                mem_commit_valid;
   logic [MEM_NUM*ROB_AW-1:0]         mem_commit_rob;
   logic [MEM_NUM*32-1:0]             mem_commit_data;
   logic [ALU_NUM-1:0]                branch_commit_valid;
   logic [ALU_NUM*ROB_AW-1:0]         branch_commit_rob;
   logic [ALU_NUM-1:0]                branch_commit_taken;
   logic [ALU_NUM*32-1:0]             branch_commit_target;
   logic [RETIRE_WIDTH-1:0]           retire_valid;
   logic [RETIRE_WIDTH*32-1:0]        retire_data;
   logic [RETIRE_WIDTH*5-1:0]         retire_dst;
   logic [RETIRE_WIDTH*PREG_W-1:0]    retire_preg;
   logic                              branch_taken;
   logic [31:0]                       pcbranch;

   modport master (
      output flush, alloc_valid, alloc_dst, alloc_preg,
             alu_commit_valid, alu_commit_rob, alu_commit_data,
             mem_commit_valid, mem_commit_rob, mem_commit_data,
             branch_commit_valid, branch_commit_rob, branch_commit_taken, branch_commit_target,
      input  rob_addr_new, rob_full, retire_valid, retire_data, retire_dst, retire_preg,
             branch_taken, pcbranch
   );
   modport slave (
      input  flush, alloc_valid, alloc_dst, alloc_preg,
             alu_commit_valid, alu_commit_rob, alu_commit_data,
             mem_commit_valid, mem_commit_rob, mem_commit_data,
             branch_commit_valid, branch_commit_rob, branch_commit_taken, branch_commit_target,
      output rob_addr_new, rob_full, retire_valid, retire_data, retire_dst, retire_preg,
             branch_taken, pcbranch
   );
endinterface

// File: rtl/rob_entry_array.sv
// rob_entry_array: ROB entry storage with allocation/completion writes, head-relative reads and global clear
module rob_entry_array
   import rob_pkg::*;
(
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            clear,
   input  logic [MACHINE_WIDTH-1:0]        we,
   input  rob_addr_t                       waddr [MACHINE_WIDTH],
   input  logic [MACHINE_WIDTH*5-1:0]      wdst,
   input  logic [MACHINE_WIDTH*PREG_W-1:0] wpreg,
   input  cmt_t                            cmt [CMT_NUM],
   input  rob_addr_t                       head,
   input  logic [RETIRE_WIDTH-1:0]         rclr,
   output rob_entry_t                      rd [RETIRE_WIDTH]
);
   rob_entry_t mem [ROB_DEPTH];

   for (genvar j = 0; j < RETIRE_WIDTH; j++) begin : g_rd
      assign rd[j] = mem[head + rob_addr_t'(j)];
   end

   // retirement clears are applied last so they win over a late completion
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) mem <= '{default: '0};
      else if (clear) mem <= '{default: '0};
      else begin
         for (int p = 0; p < CMT_NUM; p++)
            if (cmt[p].valid && mem[cmt[p].rob].valid) begin
               mem[cmt[p].rob].done <= 1'b1;
               if (cmt[p].br) begin
                  mem[cmt[p].rob].mispredict <= cmt[p].taken;
                  mem[cmt[p].rob].target     <= cmt[p].data;
               end else mem[cmt[p].rob].data <= cmt[p].data;
            end
         for (int l = 0; l < MACHINE_WIDTH; l++)
            if (we[l]) mem[waddr[l]] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                          dst: wdst[l*5 +: 5], preg: wpreg[l*PREG_W +: PREG_W],
                                          data: '0, target: '0};
         for (int j = 0; j < RETIRE_WIDTH; j++)
            if (rclr[j]) mem[head + rob_addr_t'(j)].valid <= 1'b0;
      end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with out-of-order completion and mispredict squash
module reorder_buffer
   import rob_pkg::*;
(
   input logic             clk,
   input logic             resetn,
   reorder_buffer_if.slave rb
);
   rob_ptr_t                 head, tail, count, nret, nalloc;
   rob_addr_t                off;
   rob_addr_t                waddr [MACHINE_WIDTH];
   logic [MACHINE_WIDTH-1:0] we;
   logic [RETIRE_WIDTH-1:0]  ret;
   logic                     ok, mis, alloc_en;
   logic [31:0]              mis_target;
   cmt_t                     cmt [CMT_NUM];
   rob_entry_t               rd [RETIRE_WIDTH];

   assign count    = tail - head;
   assign rb.rob_full = count > rob_ptr_t'(ROB_DEPTH - MACHINE_WIDTH);
   assign alloc_en = !rb.rob_full && !rb.flush && !mis;

   for (genvar i = 0; i < ALU_NUM; i++) begin : g_alu
      assign cmt[i] = '{valid: rb.alu_commit_valid[i], br: 1'b0, taken: 1'b0,
                        rob: rb.alu_commit_rob[i*ROB_AW +: ROB_AW], data: rb.alu_commit_data[i*32 +: 32]};
      assign cmt[ALU_NUM+i] = '{valid: rb.branch_commit_valid[i], br: 1'b1, taken: rb.branch_commit_taken[i],
                                rob: rb.branch_commit_rob[i*ROB_AW +: ROB_AW],
                                data: rb.branch_commit_target[i*32 +: 32]};
   end
   for (genvar i = 0; i < MEM_NUM; i++) begin : g_mem
      assign cmt[2*ALU_NUM+i] = '{valid: rb.mem_commit_valid[i], br: 1'b0, taken: 1'b0,
                                  rob: rb.mem_commit_rob[i*ROB_AW +: ROB_AW],
                                  data: rb.mem_commit_data[i*32 +: 32]};
   end

   // invalid lanes still report the next free slot so the renamer sees a stable index
   always_comb begin
      off = '0;
      nalloc = '0;
      we = '0;
      waddr = '{default: '0};
      rb.rob_addr_new = '0;
      for (int l = 0; l < MACHINE_WIDTH; l++) begin
         waddr[l] = tail[ROB_AW-1:0] + off;
         rb.rob_addr_new[l*ROB_AW +: ROB_AW] = waddr[l];
         we[l] = alloc_en && rb.alloc_valid[l];
         off = off + rob_addr_t'(rb.alloc_valid[l]);
         nalloc = nalloc + rob_ptr_t'(we[l]);
      end
   end

   // a retiring mispredict stops the lanes behind it; flush blocks retirement outright
   always_comb begin
      ok = !rb.flush;
      ret = '0;
      nret = '0;
      mis = 1'b0;
      mis_target = '0;
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
         ret[j] = ok && rd[j].valid && rd[j].done;
         ok = ret[j] && !rd[j].mispredict;
         nret = nret + rob_ptr_t'(ret[j]);
         mis_target = ret[j] && rd[j].mispredict ? rd[j].target : mis_target;
         mis = mis || (ret[j] && rd[j].mispredict);
      end
   end

   rob_entry_array u_arr (
      .clk   (clk),
      .resetn(resetn),
      .clear (rb.flush || mis),
      .we    (we),
      .waddr (waddr),
      .wdst  (rb.alloc_dst),
      .wpreg (rb.alloc_preg),
      .cmt   (cmt),
      .head  (head[ROB_AW-1:0]),
      .rclr  (ret),
      .rd    (rd)
   );

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         head            <= '0;
         tail            <= '0;
         rb.retire_valid <= '0;
         rb.retire_data  <= '0;
         rb.retire_dst   <= '0;
         rb.retire_preg  <= '0;
         rb.branch_taken <= 1'b0;
         rb.pcbranch     <= '0;
      end else begin
         head            <= rb.flush ? '0 : head + nret;
         tail            <= rb.flush ? '0 : mis ? head + nret : tail + nalloc;
         rb.retire_valid <= ret;
         rb.branch_taken <= mis;
         rb.pcbranch     <= mis_target;
         for (int j = 0; j < RETIRE_WIDTH; j++) begin
            rb.retire_data[j*32 +: 32]         <= ret[j] ? rd[j].data : '0;
            rb.retire_dst[j*5 +: 5]            <= ret[j] ? rd[j].dst : '0;
            rb.retire_preg[j*PREG_W +: PREG_W] <= ret[j] ? rd[j].preg : '0;
         end
      end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic against a queue-based ROB model
module tb_reorder_buffer;
   import rob_pkg::*;

   typedef struct {
      bit                done, mis, has_data;
      logic [4:0]        dst;
      logic [PREG_W-1:0] preg;
      logic [31:0]       data, target;
   } ment_t;

   logic  clk = 1'b0;
   logic  resetn = 1'b0;
   int    n_cmp = 0;
   int    n_bad = 0;
   ment_t q[$];
   int    hd = 0;

   reorder_buffer_if rb();
   reorder_buffer dut (.clk(clk), .resetn(resetn), .rb(rb));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pos_of(logic [ROB_AW-1:0] idx);
      return (int'(idx) - hd + ROB_DEPTH) % ROB_DEPTH;
   endfunction

   function automatic void commit_model(logic [ROB_AW-1:0] idx, bit br, bit tk, logic [31:0] d);
      int p = pos_of(idx);
      ment_t e;
      if (p >= q.size()) return;
      e = q[p];
      e.done = 1'b1;
      if (br) begin
         e.mis = tk;
         e.target = d;
      end else begin
         e.has_data = 1'b1;
         e.data = d;
      end
      q[p] = e;
   endfunction

   task automatic clr_in();
      rb.flush = 1'b0;
      rb.alloc_valid = '0;
      rb.alu_commit_valid = '0;
      rb.mem_commit_valid = '0;
      rb.branch_commit_valid = '0;
      rb.branch_commit_taken = '0;
   endtask

   task automatic set_alloc(logic [MACHINE_WIDTH-1:0] v);
      rb.alloc_valid = v;
      rb.alloc_dst = (MACHINE_WIDTH*5)'($urandom);
      rb.alloc_preg = (MACHINE_WIDTH*PREG_W)'($urandom);
   endtask

   task automatic alu(int p, int idx, logic [31:0] d);
      rb.alu_commit_valid[p] = 1'b1;
      rb.alu_commit_rob[p*ROB_AW +: ROB_AW] = rob_addr_t'(idx);
      rb.alu_commit_data[p*32 +: 32] = d;
   endtask

   task automatic mem(int p, int idx, logic [31:0] d);
      rb.mem_commit_valid[p] = 1'b1;
      rb.mem_commit_rob[p*ROB_AW +: ROB_AW] = rob_addr_t'(idx);
      rb.mem_commit_data[p*32 +: 32] = d;
   endtask

   task automatic br(int p, int idx, bit tk, logic [31:0] t);
      rb.branch_commit_valid[p] = 1'b1;
      rb.branch_commit_rob[p*ROB_AW +: ROB_AW] = rob_addr_t'(idx);
      rb.branch_commit_taken[p] = tk;
      rb.branch_commit_target[p*32 +: 32] = t;
   endtask

   // one clock: check combinational outputs, advance the model, check registered outputs
   task automatic tick();
      int tl, nv, k;
      bit full, mis;
      logic [31:0] tgt;
      logic [RETIRE_WIDTH-1:0] ev;
      ment_t rv [RETIRE_WIDTH];
      ment_t e;
      #1;
      full = (ROB_DEPTH - q.size()) < MACHINE_WIDTH;
      check("rob_full", 64'(rb.rob_full), 64'(full));
      tl = (hd + q.size()) % ROB_DEPTH;
      nv = 0;
      for (int l = 0; l < MACHINE_WIDTH; l++) begin
         check("rob_addr_new", 64'(rb.rob_addr_new[l*ROB_AW +: ROB_AW]), 64'((tl + nv) % ROB_DEPTH));
         nv += int'(rb.alloc_valid[l]);
      end
      ev = '0;
      mis = 1'b0;
      tgt = '0;
      k = 0;
      if (rb.flush) begin
         q.delete();
         hd = 0;
      end else begin
         while (k < RETIRE_WIDTH && k < q.size() && !mis && q[k].done) begin
            ev[k] = 1'b1;
            rv[k] = q[k];
            mis = q[k].mis;
            tgt = q[k].target;
            k++;
         end
         for (int i = 0; i < ALU_NUM; i++) begin
            if (rb.alu_commit_valid[i])
               commit_model(rb.alu_commit_rob[i*ROB_AW +: ROB_AW], 1'b0, 1'b0, rb.alu_commit_data[i*32 +: 32]);
            if (rb.branch_commit_valid[i])
               commit_model(rb.branch_commit_rob[i*ROB_AW +: ROB_AW], 1'b1, rb.branch_commit_taken[i],
                            rb.branch_commit_target[i*32 +: 32]);
         end
         for (int i = 0; i < MEM_NUM; i++)
            if (rb.mem_commit_valid[i])
               commit_model(rb.mem_commit_rob[i*ROB_AW +: ROB_AW], 1'b0, 1'b0, rb.mem_commit_data[i*32 +: 32]);
         repeat (k) void'(q.pop_front());
         hd = (hd + k) % ROB_DEPTH;
         if (mis) q.delete();
         else if (!full)
            for (int l = 0; l < MACHINE_WIDTH; l++)
               if (rb.alloc_valid[l]) begin
                  e = '{done: 1'b0, mis: 1'b0, has_data: 1'b0, dst: rb.alloc_dst[l*5 +: 5],
                        preg: rb.alloc_preg[l*PREG_W +: PREG_W], data: '0, target: '0};
                  q.push_back(e);
               end
      end
      @(posedge clk);
      #1;
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
         check("retire_valid", 64'(rb.retire_valid[j]), 64'(ev[j]));
         if (ev[j]) begin
            check("retire_dst", 64'(rb.retire_dst[j*5 +: 5]), 64'(rv[j].dst));
            check("retire_preg", 64'(rb.retire_preg[j*PREG_W +: PREG_W]), 64'(rv[j].preg));
            if (rv[j].has_data) check("retire_data", 64'(rb.retire_data[j*32 +: 32]), 64'(rv[j].data));
         end
      end
      check("branch_taken", 64'(rb.branch_taken), 64'(mis));
      if (mis) check("pcbranch", 64'(rb.pcbranch), 64'(tgt));
   endtask

   task automatic rand_stim();
      int cand[$];
      int c, idx;
      clr_in();
      rb.flush = ($urandom_range(0, 59) == 0);
      set_alloc($urandom_range(0, 1) != 0 ? '1 : MACHINE_WIDTH'($urandom));
      for (int i = 0; i < q.size(); i++) if (!q[i].done) cand.push_back(i);
      for (int pt = 0; pt < CMT_NUM; pt++)
         if (cand.size() > 0 && $urandom_range(0, 3) == 0) begin
            c = int'($urandom_range(0, cand.size() - 1));
            idx = (hd + cand[c]) % ROB_DEPTH;
            cand.delete(c);
            if (pt < ALU_NUM) alu(pt, idx, $urandom);
            else if (pt < 2 * ALU_NUM) br(pt - ALU_NUM, idx, $urandom_range(0, 7) == 0, $urandom);
            else mem(pt - 2 * ALU_NUM, idx, $urandom);
         end
      // stray completion to a slot that is neither live nor being allocated
      if (!rb.alu_commit_valid[0] && q.size() + MACHINE_WIDTH < ROB_DEPTH && $urandom_range(0, 7) == 0)
         alu(0, (hd + int'($urandom_range(q.size() + MACHINE_WIDTH, ROB_DEPTH - 1))) % ROB_DEPTH, $urandom);
   endtask

   task automatic do_flush();
      clr_in();
      rb.flush = 1'b1;
      tick();
      clr_in();
   endtask

   initial begin
      clr_in();
      rb.alloc_dst = '0;
      rb.alloc_preg = '0;
      rb.alu_commit_rob = '0;
      rb.alu_commit_data = '0;
      rb.mem_commit_rob = '0;
      rb.mem_commit_data = '0;
      rb.branch_commit_rob = '0;
      rb.branch_commit_target = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check("reset rob_full", 64'(rb.rob_full), 64'(0));
      check("reset retire_valid", 64'(rb.retire_valid), 64'(0));
      check("reset retire_data", 64'(rb.retire_data), 64'(0));
      check("reset branch_taken", 64'(rb.branch_taken), 64'(0));
      check("reset pcbranch", 64'(rb.pcbranch), 64'(0));

      // fill with paired allocations, then keep pushing while full
      repeat (9) begin
         clr_in();
         set_alloc('1);
         tick();
      end
      do_flush();

      // completion out of order; nothing may leave until index 0 is done
      set_alloc('1);
      tick();
      tick();
      foreach (q[i]) if (i > 0) begin
         clr_in();
         alu(0, 4 - i, $urandom);
         tick();
      end
      clr_in();
      alu(0, 0, 32'hDEADBEEF);
      tick();
      clr_in();
      repeat (3) tick();

      // full buffer drains completely, next allocations wrap onto indices 0..3
      do_flush();
      repeat (8) begin
         clr_in();
         set_alloc('1);
         tick();
      end
      for (int c = 0; c < ROB_DEPTH; c += 3) begin
         clr_in();
         alu(0, c, $urandom);
         if (c + 1 < ROB_DEPTH) alu(1, c + 1, $urandom);
         if (c + 2 < ROB_DEPTH) mem(0, c + 2, $urandom);
         tick();
      end
      clr_in();
      repeat (8) tick();
      set_alloc('1);
      tick();
      tick();

      // taken branch at the head squashes everything behind it
      clr_in();
      br(0, 0, 1'b1, 32'hBFC00380);
      alu(0, 1, $urandom);
      alu(1, 2, $urandom);
      mem(0, 3, $urandom);
      tick();
      clr_in();
      repeat (4) tick();
      set_alloc(MACHINE_WIDTH'(1));
      tick();

      // two retire and two allocate at count 14, then flush
      do_flush();
      repeat (6) begin
         clr_in();
         set_alloc('1);
         tick();
      end
      clr_in();
      set_alloc('1);
      alu(0, 0, $urandom);
      alu(1, 1, $urandom);
      tick();
      clr_in();
      set_alloc('1);
      tick();
      clr_in();
      rb.flush = 1'b1;
      set_alloc('1);
      tick();
      clr_in();
      tick();

      // asynchronous reset while two entries are on the retire outputs
      set_alloc('1);
      tick();
      tick();
      clr_in();
      alu(0, 0, $urandom);
      alu(1, 1, $urandom);
      mem(0, 2, $urandom);
      br(1, 3, 1'b0, $urandom);
      tick();
      clr_in();
      tick();
      #2;
      resetn = 1'b0;
      #1;
      check("async retire_valid", 64'(rb.retire_valid), 64'(0));
      check("async retire_data", 64'(rb.retire_data), 64'(0));
      check("async retire_dst", 64'(rb.retire_dst), 64'(0));
      check("async retire_preg", 64'(rb.retire_preg), 64'(0));
      check("async branch_taken", 64'(rb.branch_taken), 64'(0));
      check("async pcbranch", 64'(rb.pcbranch), 64'(0));
      check("async rob_full", 64'(rb.rob_full), 64'(0));
      q.delete();
      hd = 0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      set_alloc('1);
      tick();
      clr_in();
      repeat (3) tick();

      repeat (800) begin
         rand_stim();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
